// File: rtl/hazard_controller.sv
// hazard_controller: RV32I five-stage pipeline sequencer.
// Detects decode-vs-execute/memory register dependencies, registers the
// execute-stage forwarding selects, and sequences load-use stalls and
// taken-branch flushes through a small FSM.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_count / flush_count.
module hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] rs2_addr_dec,
  input  logic                  rs1_used_dec,
  input  logic                  rs2_used_dec,
  input  logic [REG_ADDR_W-1:0] rd_addr_ex,
  input  logic                  reg_write_ex,
  input  logic                  is_load_ex,
  input  logic [REG_ADDR_W-1:0] rd_addr_mem,
  input  logic                  reg_write_mem,
  input  logic                  branch_taken_ex,
  output logic [1:0]            forward_control_src1,
  output logic [1:0]            forward_control_src2,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  bubble_execute,
  output logic                  flush_decode,
  output logic [1:0]            state_out
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] fwd1_d, fwd2_d;
  logic       match_ex_1, match_ex_2, match_mem_1, match_mem_2;
  logic       load_use;

  // Dependency compare of the decode sources against in-flight destinations
  always_comb begin
    match_ex_1  = rs1_used_dec & reg_write_ex  & (rd_addr_ex  == rs1_addr_dec) & (rs1_addr_dec != '0);
    match_ex_2  = rs2_used_dec & reg_write_ex  & (rd_addr_ex  == rs2_addr_dec) & (rs2_addr_dec != '0);
    match_mem_1 = rs1_used_dec & reg_write_mem & (rd_addr_mem == rs1_addr_dec) & (rs1_addr_dec != '0);
    match_mem_2 = rs2_used_dec & reg_write_mem & (rd_addr_mem == rs2_addr_dec) & (rs2_addr_dec != '0);
    load_use    = is_load_ex & (match_ex_1 | match_ex_2);
  end

  // Forward select candidates; the execute-stage producer wins over memory
  always_comb begin
    fwd1_d = 2'b00;
    fwd2_d = 2'b00;
    if (match_ex_1 && !is_load_ex) fwd1_d = 2'b01;
    else if (match_mem_1)          fwd1_d = 2'b10;
    if (match_ex_2 && !is_load_ex) fwd2_d = 2'b01;
    else if (match_mem_2)          fwd2_d = 2'b10;
  end

  // Next-state and pipeline control decode
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    bubble_execute = 1'b0;
    flush_decode   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken_ex) begin
          // the branch cycle itself is the first squash cycle
          flush_decode   = 1'b1;
          bubble_execute = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (load_use) begin
          stall_fetch    = 1'b1;
          stall_decode   = 1'b1;
          bubble_execute = 1'b1;
          state_d        = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = RUN;
      FLUSH: begin
        // branch_taken_ex is ignored: only bubbles occupy execute here
        if (cnt_q != '0) begin
          flush_decode   = 1'b1;
          bubble_execute = 1'b1;
          cnt_d          = cnt_q - 3'd1;
        end
        if (cnt_q <= 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!rst_n) begin
      stall_fetch    = 1'b0;
      stall_decode   = 1'b0;
      bubble_execute = 1'b0;
      flush_decode   = 1'b0;
    end
  end

  // State, flush counter and forward select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= RUN;
      cnt_q                <= '0;
      forward_control_src1 <= 2'b00;
      forward_control_src2 <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // squash cycles clear the selects; a load-use stall keeps them
      if (flush_decode) begin
        forward_control_src1 <= 2'b00;
        forward_control_src2 <= 2'b00;
      end else if (!stall_decode) begin
        forward_control_src1 <= fwd1_d;
        forward_control_src2 <= fwd2_d;
      end
    end
  end

  assign state_out = state_q;

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters for stall and flush cycles, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_fetch)  stall_count <= stall_count + 32'd1;
      if (flush_decode) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: table-driven forwarding vectors plus
// hand-written load-use, branch and reset sequences.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_addr_dec, rs2_addr_dec, rd_addr_ex, rd_addr_mem;
  logic       rs1_used_dec, rs2_used_dec, reg_write_ex, is_load_ex;
  logic       reg_write_mem, branch_taken_ex;
  logic [1:0] forward_control_src1, forward_control_src2, state_out;
  logic       stall_fetch, stall_decode, bubble_execute, flush_decode;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
  logic [31:0] sc0, fc0;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  hazard_controller #(.FLUSH_CYCLES(2), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_dec(rs1_addr_dec), .rs2_addr_dec(rs2_addr_dec),
    .rs1_used_dec(rs1_used_dec), .rs2_used_dec(rs2_used_dec),
    .rd_addr_ex(rd_addr_ex), .reg_write_ex(reg_write_ex), .is_load_ex(is_load_ex),
    .rd_addr_mem(rd_addr_mem), .reg_write_mem(reg_write_mem),
    .branch_taken_ex(branch_taken_ex),
    .forward_control_src1(forward_control_src1), .forward_control_src2(forward_control_src2),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .bubble_execute(bubble_execute), .flush_decode(flush_decode),
    .state_out(state_out)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rdex;
    logic       wex, ldex;
    logic [4:0] rdmem;
    logic       wmem;
    logic [1:0] f1, f2;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {stall_fetch, stall_decode, bubble_execute, flush_decode}
  function automatic logic [3:0] ctl();
    return {stall_fetch, stall_decode, bubble_execute, flush_decode};
  endfunction

  task automatic idle_inputs();
    rs1_addr_dec = '0; rs2_addr_dec = '0; rs1_used_dec = 0; rs2_used_dec = 0;
    rd_addr_ex = '0; reg_write_ex = 0; is_load_ex = 0;
    rd_addr_mem = '0; reg_write_mem = 0; branch_taken_ex = 0;
  endtask

  initial begin
    //            rs1 rs2 u1 u2 rdex wex ld rdmem wmem f1     f2
    vecs[0] = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 5'd0, 0, 2'b01, 2'b00}; // ALU back-to-back
    vecs[1] = '{5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 5'd7, 1, 2'b00, 2'b01}; // double producer
    vecs[2] = '{5'd0, 5'd7, 0, 1, 5'd8, 1, 0, 5'd7, 1, 2'b00, 2'b10}; // mem only
    vecs[3] = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 5'd0, 1, 2'b00, 2'b00}; // x0
    vecs[4] = '{5'd0, 5'd9, 0, 0, 5'd9, 1, 0, 5'd9, 1, 2'b00, 2'b00}; // rs2 unused
    vecs[5] = '{5'd4, 5'd4, 1, 1, 5'd6, 1, 0, 5'd4, 1, 2'b10, 2'b10}; // both from mem
    vecs[6] = '{5'd3, 5'd0, 1, 0, 5'd3, 0, 0, 5'd3, 0, 2'b00, 2'b00}; // no writers
    vecs[7] = '{5'd12, 5'd13, 1, 1, 5'd12, 1, 0, 5'd13, 1, 2'b01, 2'b10};
    vecs[8] = '{5'd10, 5'd0, 1, 0, 5'd11, 1, 1, 5'd10, 1, 2'b10, 2'b00}; // load, no ex match
    vecs[9] = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 5'd0, 1, 2'b00, 2'b00}; // load to x0

    // reset with random inputs
    rst_n = 0;
    rs1_addr_dec = 5'($urandom); rs2_addr_dec = 5'($urandom);
    rs1_used_dec = 1; rs2_used_dec = 1; rd_addr_ex = rs1_addr_dec;
    reg_write_ex = 1; is_load_ex = 1; rd_addr_mem = rs2_addr_dec; reg_write_mem = 1;
    branch_taken_ex = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 32'(ctl()), 32'h0);
    chk("reset_state", 32'(state_out), 32'h0);
    chk("reset_fwd", 32'({forward_control_src1, forward_control_src2}), 32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_reset_ctl", 32'(ctl()), 32'h0);
    chk("post_reset_fwd", 32'({forward_control_src1, forward_control_src2}), 32'h0);

    // table-driven forwarding vectors, all single-cycle in RUN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rs1_addr_dec = vecs[i].rs1; rs2_addr_dec = vecs[i].rs2;
      rs1_used_dec = vecs[i].u1;  rs2_used_dec = vecs[i].u2;
      rd_addr_ex = vecs[i].rdex;  reg_write_ex = vecs[i].wex; is_load_ex = vecs[i].ldex;
      rd_addr_mem = vecs[i].rdmem; reg_write_mem = vecs[i].wmem;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_fwd1", i), 32'(forward_control_src1), 32'(vecs[i].f1));
      chk($sformatf("vec%0d_fwd2", i), 32'(forward_control_src2), 32'(vecs[i].f2));
      chk($sformatf("vec%0d_state", i), 32'(state_out), 32'h0);
    end

`ifdef HAZARD_PERF_CNT_EN
    sc0 = stall_count; fc0 = flush_count;
`endif

    // load-use: one stall cycle, then forward from memory
    @(negedge clk);
    idle_inputs();
    is_load_ex = 1; reg_write_ex = 1; rd_addr_ex = 5'd3;
    rs1_addr_dec = 5'd3; rs1_used_dec = 1;
    #1;
    chk("lu_ctl", 32'(ctl()), 32'hE);
    chk("lu_state0", 32'(state_out), 32'h0);
    @(negedge clk);
    chk("lu_state1", 32'(state_out), 32'h1);
    idle_inputs();
    rs1_addr_dec = 5'd3; rs1_used_dec = 1; rd_addr_mem = 5'd3; reg_write_mem = 1;
    #1;
    chk("lu_stall_ctl", 32'(ctl()), 32'h0);
    @(posedge clk); #1;
    chk("lu_fwd1", 32'(forward_control_src1), 32'h2);
    chk("lu_state2", 32'(state_out), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_stall_count", stall_count - sc0, 32'd1);
    sc0 = stall_count;
`endif

    // preload a nonzero select so the flush clearing is visible
    @(negedge clk);
    idle_inputs();
    rs1_addr_dec = 5'd5; rs1_used_dec = 1; rd_addr_ex = 5'd5; reg_write_ex = 1;
    @(posedge clk); #1;
    chk("pre_br_fwd1", 32'(forward_control_src1), 32'h1);

    // branch over load-use: two squash cycles, no stall
    @(negedge clk);
    idle_inputs();
    branch_taken_ex = 1; is_load_ex = 1; reg_write_ex = 1; rd_addr_ex = 5'd3;
    rs1_addr_dec = 5'd3; rs1_used_dec = 1;
    #1;
    chk("br_ctl0", 32'(ctl()), 32'h3);
    @(negedge clk);
    chk("br_state1", 32'(state_out), 32'h2);
    chk("br_fwd_cleared", 32'(forward_control_src1), 32'h0);
    #1;
    chk("br_ctl1", 32'(ctl()), 32'h3);
    @(negedge clk);
    chk("br_state2", 32'(state_out), 32'h0);
    branch_taken_ex = 0; is_load_ex = 0; reg_write_ex = 0;
    #1;
    chk("br_ctl2", 32'(ctl()), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    chk("br_flush_count", flush_count - fc0, 32'd2);
    chk("br_stall_count", stall_count - sc0, 32'd0);
`endif

    // asynchronous reset in the middle of a flush
    @(negedge clk);
    idle_inputs();
    branch_taken_ex = 1;
    @(negedge clk);
    chk("mid_flush_state", 32'(state_out), 32'h2);
    #2;
    rst_n = 0;
    #1;
    chk("abort_state", 32'(state_out), 32'h0);
    chk("abort_ctl", 32'(ctl()), 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("after_abort_ctl", 32'(ctl()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
